// File: rtl/rf_pkg.sv
// Shared constants and slicing helper for the multi-port register file.
// Port k of a flattened bus occupies bits [port_lo(k, width) +: width].
package rf_pkg;

  localparam int RF_MIN_PORTS = 1;
  localparam int RF_MAX_RD    = 4;
  localparam int RF_MAX_WR    = 2;

  function automatic int port_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle between the pipeline (master) and the register file (slave):
// writeback ports, read ports, producer issue and the scoreboard vector.
interface register_file_mp_if #(
  parameter int N      = 32,
  parameter int ADDR   = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
);

  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*ADDR-1:0] wr_addr;
  logic [NUM_WR*N-1:0]    wr_data;
  logic [NUM_RD*ADDR-1:0] rd_addr;
  logic [NUM_RD*N-1:0]    rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic                   iss_en;
  logic [ADDR-1:0]        iss_addr;
  logic [2**ADDR-1:0]     busy;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr,
    input  rd_data, rd_busy, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr,
    output rd_data, rd_busy, busy
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-write bits: set by producer issue, cleared by writeback.
// When both happen to the same register on one edge, the newer producer keeps it busy.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR     = 5,
  parameter int NUM_WR   = 1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iss_en,
  input  logic [ADDR-1:0]        iss_addr,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*ADDR-1:0] wr_addr,
  output logic [2**ADDR-1:0]     busy
);

  localparam int DEPTH = 2**ADDR;

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_busy
    if (ZERO_REG && gi == 0) begin : g_zero
      assign busy[gi] = 1'b0;
    end else begin : g_bit
      logic set_next;
      logic clr_next;
      logic busy_reg;

      always_comb begin
        set_next = iss_en && (iss_addr == ADDR'(gi));
        clr_next = 1'b0;
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_en[k] && (wr_addr[port_lo(k, ADDR) +: ADDR] == ADDR'(gi))) begin
            clr_next = 1'b1;
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          busy_reg <= 1'b0;
        end else if (set_next) begin
          busy_reg <= 1'b1;
        end else if (clr_next) begin
          busy_reg <= 1'b0;
        end
      end

      assign busy[gi] = busy_reg;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with write-to-read bypass, optional hardwired zero
// register and a pending-write scoreboard. Higher write port index wins on conflicts.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int N        = 32,
  parameter int ADDR     = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic               clk,
  input logic               reset,
  register_file_mp_if.slave bus
);

  localparam int DEPTH = 2**ADDR;

  logic [N-1:0]     mem [DEPTH];
  logic [DEPTH-1:0] busy;

  rf_scoreboard #(
    .ADDR     (ADDR),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .busy     (busy)
  );

  assign bus.busy = busy;

  genvar gi;

  // Storage: each register picks the highest-indexed enabled port aimed at it.
  for (gi = 0; gi < DEPTH; gi++) begin : g_reg
    if (ZERO_REG && gi == 0) begin : g_zero
      assign mem[gi] = '0;
    end else begin : g_store
      logic         wr_hit;
      logic [N-1:0] q_next;
      logic [N-1:0] q_reg;

      always_comb begin
        wr_hit = 1'b0;
        q_next = '0;
        for (int k = 0; k < NUM_WR; k++) begin
          if (bus.wr_en[k] && (bus.wr_addr[port_lo(k, ADDR) +: ADDR] == ADDR'(gi))) begin
            wr_hit = 1'b1;
            q_next = bus.wr_data[port_lo(k, N) +: N];
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q_reg <= '0;
        end else if (wr_hit) begin
          q_reg <= q_next;
        end
      end

      assign mem[gi] = q_reg;
    end
  end

  // Read ports: in-flight writeback overrides storage and hides the busy bit.
  for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR-1:0] ra;
    logic            byp_hit;
    logic [N-1:0]    byp_data;
    logic [N-1:0]    rdata;
    logic            rbusy;

    assign ra = bus.rd_addr[port_lo(gi, ADDR) +: ADDR];

    always_comb begin
      byp_hit  = 1'b0;
      byp_data = '0;
      for (int k = 0; k < NUM_WR; k++) begin
        if (BYPASS && bus.wr_en[k] && (bus.wr_addr[port_lo(k, ADDR) +: ADDR] == ra)) begin
          byp_hit  = 1'b1;
          byp_data = bus.wr_data[port_lo(k, N) +: N];
        end
      end
      rdata = byp_hit ? byp_data : mem[ra];
      rbusy = byp_hit ? 1'b0 : busy[ra];
      if (ZERO_REG && (ra == '0)) begin
        rdata = '0;
        rbusy = 1'b0;
      end
    end

    assign bus.rd_data[port_lo(gi, N) +: N] = rdata;
    assign bus.rd_busy[gi]                  = rbusy;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Two register files (bypass+zero reg, and neither) driven by the same stimulus
// and checked against a behavioural model through an expectation queue.
module tb_register_file_mp;
  import rf_pkg::*;

  localparam int N      = 32;
  localparam int ADDR   = 5;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int DEPTH  = 2**ADDR;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  register_file_mp_if #(.N(N), .ADDR(ADDR), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus_a ();
  register_file_mp_if #(.N(N), .ADDR(ADDR), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus_b ();

  register_file_mp #(
    .N(N), .ADDR(ADDR), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  register_file_mp #(
    .N(N), .ADDR(ADDR), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ZERO_REG(1'b0), .BYPASS(1'b0)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // Stimulus shared by both instances
  logic [NUM_WR-1:0] wr_en    = '0;
  logic [ADDR-1:0]   wa [NUM_WR];
  logic [N-1:0]      wd [NUM_WR];
  logic [ADDR-1:0]   ra [NUM_RD];
  logic              iss_en   = 1'b0;
  logic [ADDR-1:0]   iss_addr = '0;

  assign bus_a.wr_en    = wr_en;
  assign bus_a.wr_addr  = {wa[1], wa[0]};
  assign bus_a.wr_data  = {wd[1], wd[0]};
  assign bus_a.rd_addr  = {ra[1], ra[0]};
  assign bus_a.iss_en   = iss_en;
  assign bus_a.iss_addr = iss_addr;
  assign bus_b.wr_en    = wr_en;
  assign bus_b.wr_addr  = {wa[1], wa[0]};
  assign bus_b.wr_data  = {wd[1], wd[0]};
  assign bus_b.rd_addr  = {ra[1], ra[0]};
  assign bus_b.iss_en   = iss_en;
  assign bus_b.iss_addr = iss_addr;

  // Reference model; index 0 = dut_a, 1 = dut_b
  logic [N-1:0]     m_mem  [2][DEPTH];
  logic [DEPTH-1:0] m_busy [2];
  bit               m_zero [2] = '{1'b1, 1'b0};
  bit               m_byp  [2] = '{1'b1, 1'b0};

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  int n_total = 0;
  int n_bad   = 0;
  int txn     = 0;

  logic [N-1:0]      last_rd    [2][NUM_RD];
  logic [NUM_RD-1:0] last_rbusy [2];
  logic [DEPTH-1:0]  last_busy  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_data(input int d, input logic [ADDR-1:0] a);
    logic [N-1:0] v;
    v = m_mem[d][a];
    if (m_byp[d]) begin
      for (int k = 0; k < NUM_WR; k++) if (wr_en[k] && wa[k] == a) v = wd[k];
    end
    if (m_zero[d] && a == 0) v = '0;
    return v;
  endfunction

  function automatic logic exp_rbusy(input int d, input logic [ADDR-1:0] a);
    logic b;
    b = m_busy[d][a];
    if (m_byp[d]) begin
      for (int k = 0; k < NUM_WR; k++) if (wr_en[k] && wa[k] == a) b = 1'b0;
    end
    if (m_zero[d] && a == 0) b = 1'b0;
    return b;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = '0;
      for (int r = 0; r < DEPTH; r++) m_mem[d][r] = '0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < DEPTH; r++) begin
        bit hit_w;
        hit_w = 1'b0;
        for (int k = 0; k < NUM_WR; k++) if (wr_en[k] && wa[k] == ADDR'(r)) hit_w = 1'b1;
        if (iss_en && iss_addr == ADDR'(r) && !(m_zero[d] && r == 0)) m_busy[d][r] = 1'b1;
        else if (hit_w) m_busy[d][r] = 1'b0;
      end
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && !(m_zero[d] && wa[k] == 0)) m_mem[d][wa[k]] = wd[k];
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < NUM_RD; j++) begin
        e.tag = $sformatf("%s.rd_data%0d@r%0d", (d == 0) ? "a" : "b", j, ra[j]);
        e.val = exp_data(d, ra[j]);
        sb_q.push_back(e);
        e.tag = $sformatf("%s.rd_busy%0d@r%0d", (d == 0) ? "a" : "b", j, ra[j]);
        e.val = 32'(exp_rbusy(d, ra[j]));
        sb_q.push_back(e);
      end
      e.tag = $sformatf("%s.busy", (d == 0) ? "a" : "b");
      e.val = m_busy[d];
      sb_q.push_back(e);
    end
  endtask

  task automatic pop_cmp();
    exp_t e;
    logic [N-1:0]      od;
    logic [NUM_RD-1:0] orb;
    logic [DEPTH-1:0]  ob;
    for (int d = 0; d < 2; d++) begin
      orb = (d == 0) ? bus_a.rd_busy : bus_b.rd_busy;
      ob  = (d == 0) ? bus_a.busy : bus_b.busy;
      for (int j = 0; j < NUM_RD; j++) begin
        od = (d == 0) ? bus_a.rd_data[port_lo(j, N) +: N] : bus_b.rd_data[port_lo(j, N) +: N];
        last_rd[d][j] = od;
        e = sb_q.pop_front();
        chk(e.tag, od, e.val);
        e = sb_q.pop_front();
        chk(e.tag, 32'(orb[j]), e.val);
      end
      last_rbusy[d] = orb;
      last_busy[d]  = ob;
      e = sb_q.pop_front();
      chk(e.tag, ob, e.val);
    end
  endtask

  // One clock transaction: drive after negedge, sample 2ns later, model the edge
  task automatic step(input logic [NUM_WR-1:0] we,
                      input logic [ADDR-1:0] a0, input logic [N-1:0] d0,
                      input logic [ADDR-1:0] a1, input logic [N-1:0] d1,
                      input logic ie, input logic [ADDR-1:0] ia,
                      input logic [ADDR-1:0] r0, input logic [ADDR-1:0] r1);
    @(negedge clk);
    wr_en = we; wa[0] = a0; wd[0] = d0; wa[1] = a1; wd[1] = d1;
    iss_en = ie; iss_addr = ia; ra[0] = r0; ra[1] = r1;
    txn++;
    $display("txn %0d we=%b w0=r%0d:%h w1=r%0d:%h iss=%b:r%0d rd=r%0d/r%0d",
             txn, we, a0, d0, a1, d1, ie, ia, r0, r1);
    push_exp();
    #2;
    pop_cmp();
    @(posedge clk);
    if (!reset) model_edge();
  endtask

  task automatic reset_sweep();
    for (int r = 0; r < DEPTH; r++) begin
      @(negedge clk);
      wr_en = '0; iss_en = 1'b0;
      ra[0] = ADDR'(r); ra[1] = ADDR'(DEPTH - 1 - r);
      push_exp();
      #2;
      pop_cmp();
    end
  endtask

  initial begin
    wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0; ra[0] = '0; ra[1] = '0;
    model_clear();
    reset_sweep();
    @(negedge clk);
    reset = 1'b0;

    // Same-cycle bypass vs registered read of r5
    step(2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5, 5);
    chk("byp_r5_a", last_rd[0][0], 32'hDEADBEEF);
    chk("nobyp_r5_b", last_rd[1][0], 32'h0);
    step(2'b00, 0, 0, 0, 0, 0, 0, 5, 6);
    chk("r5_a", last_rd[0][0], 32'hDEADBEEF);
    chk("r5_b", last_rd[1][0], 32'hDEADBEEF);

    // Both write ports hit r7: port 1 wins
    step(2'b11, 7, 32'h11, 7, 32'h22, 0, 0, 7, 7);
    chk("conflict_byp_a", last_rd[0][1], 32'h22);
    step(2'b00, 0, 0, 0, 0, 0, 0, 7, 7);
    chk("conflict_a", last_rd[0][0], 32'h22);
    chk("conflict_b", last_rd[1][0], 32'h22);

    // Zero register: writes and issues to r0
    step(2'b01, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("r0_a", last_rd[0][0], 32'h0);
    chk("r0_busy_a", 32'(last_busy[0][0]), 32'h0);
    chk("r0_b", last_rd[1][0], 32'hFFFFFFFF);
    chk("r0_busy_b", 32'(last_busy[1][0]), 32'h1);

    // Scoreboard on r3: issue, writeback, then issue+writeback together
    step(2'b00, 0, 0, 0, 0, 1, 3, 3, 3);
    chk("iss_old_busy_a", 32'(last_rbusy[0][0]), 32'h0);
    step(2'b00, 0, 0, 0, 0, 0, 0, 3, 3);
    chk("iss_busy_a", 32'(last_busy[0][3]), 32'h1);
    step(2'b01, 3, 32'h55, 0, 0, 0, 0, 3, 3);
    chk("wb_rbusy_byp_a", 32'(last_rbusy[0][0]), 32'h0);
    chk("wb_rbusy_b", 32'(last_rbusy[1][0]), 32'h1);
    step(2'b00, 0, 0, 0, 0, 0, 0, 3, 3);
    chk("wb_busy_clr_a", 32'(last_busy[0][3]), 32'h0);
    step(2'b10, 0, 0, 3, 32'h77, 1, 3, 3, 3);
    step(2'b00, 0, 0, 0, 0, 0, 0, 3, 3);
    chk("set_wins_a", 32'(last_busy[0][3]), 32'h1);
    chk("set_wins_data_a", last_rd[0][0], 32'h77);

    // Reset asserted mid-burst of writes
    for (int i = 0; i < 6; i++) step(2'b11, ADDR'(i + 8), $urandom, ADDR'(i + 16), $urandom, 1, ADDR'(i + 8), 8, 16);
    #2;
    reset = 1'b1;
    model_clear();
    reset_sweep();
    @(negedge clk);
    reset = 1'b0;

    // Random mix on all ports, biased toward a few registers for conflicts
    for (int i = 0; i < 10000; i++) begin
      logic [ADDR-1:0] mask;
      mask = ($urandom_range(0, 1) == 0) ? ADDR'(7) : ADDR'(DEPTH - 1);
      step(NUM_WR'($urandom), ADDR'($urandom) & mask, $urandom, ADDR'($urandom) & mask, $urandom,
           1'($urandom), ADDR'($urandom) & mask, ADDR'($urandom) & mask, ADDR'($urandom) & mask);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
